// File: rtl/alu_if.sv
// ---------------------------------------------------------------------------
// alu_if : operand/decode bundle into the execute ALU and its result bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface alu_if #(
  parameter int WORD_SIZE = 32
);
  logic [WORD_SIZE-1:0] pc;
  logic [6:0]           opcode;
  logic [6:0]           funct7;
  logic [2:0]           funct3;
  logic [WORD_SIZE-1:0] aluIn1;
  logic [WORD_SIZE-1:0] aluIn2;
  logic [WORD_SIZE-1:0] immediate;
  logic [WORD_SIZE-1:0] aluOut;
  logic [WORD_SIZE-1:0] newpc;
  logic                 branchTaken;
  logic [WORD_SIZE-1:0] aluOut_r;
  logic [WORD_SIZE-1:0] newpc_r;
  logic                 branchTaken_r;

  modport master (
    output pc, opcode, funct7, funct3, aluIn1, aluIn2, immediate,
    input  aluOut, newpc, branchTaken, aluOut_r, newpc_r, branchTaken_r
  );

  modport slave (
    input  pc, opcode, funct7, funct3, aluIn1, aluIn2, immediate,
    output aluOut, newpc, branchTaken, aluOut_r, newpc_r, branchTaken_r
  );
endinterface

`default_nettype wire

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu : RV32IM-subset execute ALU with branch resolution and EX/MEM registers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu #(
  parameter int WORD_SIZE = 32
) (
  input  wire   clk,
  input  wire   rst,
  alu_if.slave  bus
);

  localparam logic [6:0] c_OPCODE_ALU     = 7'b0110011;
  localparam logic [6:0] c_OPCODE_ALU_IMM = 7'b0010011;
  localparam logic [6:0] c_OPCODE_BRANCH  = 7'b1100011;
  localparam logic [6:0] c_OPCODE_JUMP    = 7'b1101111;
  localparam logic [6:0] c_OPCODE_JALR    = 7'b1100111;
  localparam logic [6:0] c_OPCODE_AUIPC   = 7'b0010111;
  localparam logic [6:0] c_OPCODE_LUI     = 7'b0110111;

  localparam logic [6:0] c_ADD_OR_AND_FUNCT7 = 7'b0000000;
  localparam logic [6:0] c_SUB_FUNCT7        = 7'b0100000;
  localparam logic [6:0] c_MUL_FUNCT7        = 7'b0000001;

  localparam logic [WORD_SIZE-1:0] c_ZERO = '0;
  localparam logic [WORD_SIZE-1:0] c_FOUR = WORD_SIZE'(4);

  logic [WORD_SIZE-1:0] w_in1;
  logic [WORD_SIZE-1:0] w_in2;
  logic [WORD_SIZE-1:0] w_imm;
  logic [4:0]           w_shamt;

  logic [WORD_SIZE-1:0] w_add_rr;
  logic [WORD_SIZE-1:0] w_sub_rr;
  logic [WORD_SIZE-1:0] w_add_ri;
  logic [WORD_SIZE-1:0] w_mul_lo;
  logic [WORD_SIZE-1:0] w_sll;
  logic [WORD_SIZE-1:0] w_srl;
  logic [WORD_SIZE-1:0] w_sra;
  logic [WORD_SIZE-1:0] w_pc_plus4;
  logic [WORD_SIZE-1:0] w_pc_plus_imm;
  logic [WORD_SIZE-1:0] w_jalr_target;

  logic w_eq_rr;
  logic w_lt_rr;
  logic w_ltu_rr;
  logic w_lt_ri;
  logic w_ltu_ri;

  logic [WORD_SIZE-1:0] w_aluOut;
  logic [WORD_SIZE-1:0] w_newpc;
  logic                 w_branchTaken;

  logic [WORD_SIZE-1:0] r_aluOut;
  logic [WORD_SIZE-1:0] r_newpc;
  logic                 r_branchTaken;

  assign w_in1   = bus.aluIn1;
  assign w_in2   = bus.aluIn2;
  assign w_imm   = bus.immediate;
  // Register and immediate shifts both take the amount from aluIn2.
  assign w_shamt = bus.aluIn2[4:0];

  assign w_add_rr      = w_in1 + w_in2;
  assign w_sub_rr      = w_in1 - w_in2;
  assign w_add_ri      = w_in1 + w_imm;
  assign w_mul_lo      = w_in1 * w_in2;
  assign w_sll         = w_in1 << w_shamt;
  assign w_srl         = w_in1 >> w_shamt;
  assign w_sra         = $signed(w_in1) >>> w_shamt;
  assign w_pc_plus4    = bus.pc + c_FOUR;
  assign w_pc_plus_imm = bus.pc + w_imm;
  assign w_jalr_target = {w_add_ri[WORD_SIZE-1:1], 1'b0};

  assign w_eq_rr  = (w_in1 == w_in2);
  assign w_lt_rr  = ($signed(w_in1) < $signed(w_in2));
  assign w_ltu_rr = (w_in1 < w_in2);
  assign w_lt_ri  = ($signed(w_in1) < $signed(w_imm));
  assign w_ltu_ri = (w_in1 < w_imm);

  always_comb begin
    w_aluOut      = c_ZERO;
    w_newpc       = w_pc_plus4;
    w_branchTaken = 1'b0;

    unique case (bus.opcode)
      c_OPCODE_ALU: begin
        unique case (bus.funct7)
          c_ADD_OR_AND_FUNCT7: begin
            unique case (bus.funct3)
              3'b000:  w_aluOut = w_add_rr;
              3'b001:  w_aluOut = w_sll;
              3'b010:  w_aluOut = {{(WORD_SIZE-1){1'b0}}, w_lt_rr};
              3'b011:  w_aluOut = {{(WORD_SIZE-1){1'b0}}, w_ltu_rr};
              3'b100:  w_aluOut = w_in1 ^ w_in2;
              3'b101:  w_aluOut = w_srl;
              3'b110:  w_aluOut = w_in1 | w_in2;
              default: w_aluOut = w_in1 & w_in2;
            endcase
          end
          c_SUB_FUNCT7: begin
            if (bus.funct3 == 3'b000) begin
              w_aluOut = w_sub_rr;
            end else if (bus.funct3 == 3'b101) begin
              w_aluOut = w_sra;
            end
          end
          c_MUL_FUNCT7: begin
            w_aluOut = w_mul_lo;
          end
          default: ;
        endcase
      end

      c_OPCODE_ALU_IMM: begin
        unique case (bus.funct3)
          3'b000:  w_aluOut = w_add_ri;
          3'b001:  w_aluOut = w_sll;
          3'b010:  w_aluOut = {{(WORD_SIZE-1){1'b0}}, w_lt_ri};
          3'b011:  w_aluOut = {{(WORD_SIZE-1){1'b0}}, w_ltu_ri};
          3'b100:  w_aluOut = w_in1 ^ w_imm;
          3'b101: begin
            if (bus.funct7 == c_ADD_OR_AND_FUNCT7) begin
              w_aluOut = w_srl;
            end else if (bus.funct7 == c_SUB_FUNCT7) begin
              w_aluOut = w_sra;
            end
          end
          3'b110:  w_aluOut = w_in1 | w_imm;
          default: w_aluOut = w_in1 & w_imm;
        endcase
      end

      c_OPCODE_BRANCH: begin
        // Difference is exported so downstream can reuse it for zero tests.
        w_aluOut = w_sub_rr;
        unique case (bus.funct3)
          3'b000:  w_branchTaken = w_eq_rr;
          3'b001:  w_branchTaken = ~w_eq_rr;
          3'b100:  w_branchTaken = w_lt_rr;
          3'b101:  w_branchTaken = ~w_lt_rr;
          3'b110:  w_branchTaken = w_ltu_rr;
          3'b111:  w_branchTaken = ~w_ltu_rr;
          default: w_branchTaken = 1'b0;
        endcase
        if (w_branchTaken) begin
          w_newpc = w_pc_plus_imm;
        end
      end

      c_OPCODE_JUMP: begin
        w_aluOut      = w_pc_plus4;
        w_newpc       = w_pc_plus_imm;
        w_branchTaken = 1'b1;
      end

      c_OPCODE_JALR: begin
        w_aluOut      = w_pc_plus4;
        w_newpc       = w_jalr_target;
        w_branchTaken = 1'b1;
      end

      c_OPCODE_AUIPC: w_aluOut = w_pc_plus_imm;
      c_OPCODE_LUI:   w_aluOut = w_imm;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aluOut      <= c_ZERO;
      r_newpc       <= c_ZERO;
      r_branchTaken <= 1'b0;
    end else begin
      r_aluOut      <= w_aluOut;
      r_newpc       <= w_newpc;
      r_branchTaken <= w_branchTaken;
    end
  end

  assign bus.aluOut        = w_aluOut;
  assign bus.newpc         = w_newpc;
  assign bus.branchTaken   = w_branchTaken;
  assign bus.aluOut_r      = r_aluOut;
  assign bus.newpc_r       = r_newpc;
  assign bus.branchTaken_r = r_branchTaken;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu : directed vectors with hand-computed results for the execute ALU
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu;

  localparam int WORD_SIZE = 32;

  localparam logic [6:0] c_ALU    = 7'b0110011;
  localparam logic [6:0] c_IMM    = 7'b0010011;
  localparam logic [6:0] c_BR     = 7'b1100011;
  localparam logic [6:0] c_JAL    = 7'b1101111;
  localparam logic [6:0] c_JALR   = 7'b1100111;
  localparam logic [6:0] c_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_LUI    = 7'b0110111;
  localparam logic [6:0] c_F7_0   = 7'b0000000;
  localparam logic [6:0] c_F7_SUB = 7'b0100000;
  localparam logic [6:0] c_F7_MUL = 7'b0000001;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  alu_if #(.WORD_SIZE(WORD_SIZE)) bus ();

  alu #(.WORD_SIZE(WORD_SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] p);
    bus.opcode    = op;
    bus.funct7    = f7;
    bus.funct3    = f3;
    bus.aluIn1    = a;
    bus.aluIn2    = b;
    bus.immediate = imm;
    bus.pc        = p;
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    drive(c_ALU, c_F7_0, 3'b000, 32'd23, 32'd7, 32'd0, 32'd100);

    @(posedge clk); #1;
    check("rst_aluOut_r", bus.aluOut_r, 32'd0);
    check("rst_newpc_r",  bus.newpc_r,  32'd0);
    check("rst_taken_r",  {31'd0, bus.branchTaken_r}, 32'd0);
    check("comb_in_rst",  bus.aluOut, 32'd30);
    rst = 1'b0;

    // Register-register ALU
    check("add_newpc", bus.newpc, 32'd104);
    check("add_taken", {31'd0, bus.branchTaken}, 32'd0);
    drive(c_ALU, c_F7_SUB, 3'b000, 32'd4, 32'd2, 32'd0, 32'd0);
    check("sub", bus.aluOut, 32'd2);
    drive(c_ALU, c_F7_0, 3'b110, 32'b001011, 32'b010010, 32'd0, 32'd0);
    check("or", bus.aluOut, 32'b011011);
    drive(c_ALU, c_F7_0, 3'b111, 32'b010010, 32'b001110, 32'd0, 32'd0);
    check("and", bus.aluOut, 32'b000010);
    drive(c_ALU, c_F7_0, 3'b100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 32'd0);
    check("xor", bus.aluOut, 32'hFF00_0FF0);
    drive(c_ALU, c_F7_MUL, 3'b000, 32'd42, 32'd3, 32'd0, 32'd0);
    check("mul_pos", bus.aluOut, 32'd126);
    drive(c_ALU, c_F7_MUL, 3'b011, 32'd42, 32'hFFFF_FFFD, 32'd0, 32'd0);
    check("mul_neg", bus.aluOut, 32'hFFFF_FF82);
    drive(c_ALU, c_F7_0, 3'b010, 32'hFFFF_FFFF, 32'd4, 32'd0, 32'd0);
    check("slt", bus.aluOut, 32'd1);
    drive(c_ALU, c_F7_0, 3'b011, 32'hFFFF_FFFF, 32'd4, 32'd0, 32'd0);
    check("sltu", bus.aluOut, 32'd0);
    drive(c_ALU, c_F7_0, 3'b001, 32'd1, 32'd33, 32'd0, 32'd0);
    check("sll_shamt5", bus.aluOut, 32'd2);
    drive(c_ALU, c_F7_0, 3'b101, 32'h8000_0000, 32'd4, 32'd0, 32'd0);
    check("srl", bus.aluOut, 32'h0800_0000);
    drive(c_ALU, c_F7_SUB, 3'b101, 32'h8000_0000, 32'd4, 32'd0, 32'd0);
    check("sra", bus.aluOut, 32'hF800_0000);
    drive(c_ALU, c_F7_0, 3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    check("add_wrap", bus.aluOut, 32'd0);
    drive(c_ALU, c_F7_SUB, 3'b001, 32'd9, 32'd9, 32'd0, 32'd200);
    check("unlisted_out",   bus.aluOut, 32'd0);
    check("unlisted_newpc", bus.newpc,  32'd204);

    // Branches
    drive(c_BR, c_F7_0, 3'b000, 32'd4, 32'd3, 32'd60, 32'd400);
    check("beq_ne_out",   bus.aluOut, 32'd1);
    check("beq_ne_taken", {31'd0, bus.branchTaken}, 32'd0);
    check("beq_ne_newpc", bus.newpc, 32'd404);
    drive(c_BR, c_F7_0, 3'b000, 32'd4, 32'd4, 32'd60, 32'd400);
    check("beq_eq_out",   bus.aluOut, 32'd0);
    check("beq_eq_taken", {31'd0, bus.branchTaken}, 32'd1);
    check("beq_eq_newpc", bus.newpc, 32'd460);
    drive(c_BR, c_F7_0, 3'b001, 32'd4, 32'd4, 32'd60, 32'd400);
    check("bne_out",   bus.aluOut, 32'd0);
    check("bne_taken", {31'd0, bus.branchTaken}, 32'd0);
    drive(c_BR, c_F7_0, 3'b101, 32'd5, 32'd4, 32'd60, 32'd400);
    check("bge_taken", {31'd0, bus.branchTaken}, 32'd1);
    drive(c_BR, c_F7_0, 3'b101, 32'hFFFF_FFFF, 32'd4, 32'd60, 32'd400);
    check("bge_neg", {31'd0, bus.branchTaken}, 32'd0);
    drive(c_BR, c_F7_0, 3'b100, 32'd3, 32'd4, 32'd60, 32'd400);
    check("blt_taken", {31'd0, bus.branchTaken}, 32'd1);
    drive(c_BR, c_F7_0, 3'b100, 32'hFFFF_FFFF, 32'd4, 32'd60, 32'd400);
    check("blt_neg", {31'd0, bus.branchTaken}, 32'd1);
    drive(c_BR, c_F7_0, 3'b110, 32'hFFFF_FFFF, 32'd4, 32'd60, 32'd400);
    check("bltu_taken", {31'd0, bus.branchTaken}, 32'd0);
    check("bltu_newpc", bus.newpc, 32'd404);
    drive(c_BR, c_F7_0, 3'b111, 32'hFFFF_FFFF, 32'd4, 32'd60, 32'd400);
    check("bgeu_taken", {31'd0, bus.branchTaken}, 32'd1);
    drive(c_BR, c_F7_0, 3'b010, 32'd4, 32'd4, 32'd60, 32'd400);
    check("br_f3_010", {31'd0, bus.branchTaken}, 32'd0);

    // Immediate forms, AUIPC, LUI, jumps
    drive(c_IMM, c_F7_0, 3'b000, 32'd7, 32'hFFFF_FFFD, 32'd3, 32'd0);
    check("addi", bus.aluOut, 32'd10);
    drive(c_IMM, c_F7_0, 3'b010, 32'hFFFF_FFFE, 32'd0, 32'd1, 32'd0);
    check("slti", bus.aluOut, 32'd1);
    drive(c_IMM, c_F7_0, 3'b011, 32'hFFFF_FFFE, 32'd0, 32'd1, 32'd0);
    check("sltiu", bus.aluOut, 32'd0);
    drive(c_IMM, c_F7_0, 3'b001, 32'd1, 32'd2, 32'd8, 32'd0);
    check("slli", bus.aluOut, 32'd4);
    drive(c_IMM, c_F7_0, 3'b101, 32'd8, 32'd2, 32'd0, 32'd0);
    check("srli", bus.aluOut, 32'd2);
    drive(c_IMM, c_F7_SUB, 3'b101, 32'h8000_0000, 32'd4, 32'd0, 32'd0);
    check("srai", bus.aluOut, 32'hF800_0000);
    drive(c_AUIPC, c_F7_0, 3'b000, 32'd0, 32'd0, 32'd8, 32'd42);
    check("auipc", bus.aluOut, 32'd50);
    drive(c_LUI, c_F7_0, 3'b000, 32'd5, 32'd6, 32'd1, 32'd0);
    check("lui", bus.aluOut, 32'd1);
    drive(c_JALR, c_F7_0, 3'b000, 32'd101, 32'd0, 32'd8, 32'd400);
    check("jalr_newpc", bus.newpc, 32'd108);
    check("jalr_link",  bus.aluOut, 32'd404);
    drive(c_JAL, c_F7_0, 3'b000, 32'd0, 32'd0, 32'd8, 32'hFFFF_FFFC);
    check("jal_wrap", bus.newpc, 32'd4);
    drive(c_JAL, c_F7_0, 3'b000, 32'd0, 32'd0, 32'd60, 32'd400);
    check("jal_taken", {31'd0, bus.branchTaken}, 32'd1);
    check("jal_newpc", bus.newpc, 32'd460);
    check("jal_link",  bus.aluOut, 32'd404);

    // Registered copies one edge later, then cleared by reset
    @(posedge clk); #1;
    check("reg_aluOut", bus.aluOut_r, 32'd404);
    check("reg_newpc",  bus.newpc_r,  32'd460);
    check("reg_taken",  {31'd0, bus.branchTaken_r}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst2_aluOut_r", bus.aluOut_r, 32'd0);
    check("rst2_newpc_r",  bus.newpc_r,  32'd0);
    check("rst2_taken_r",  {31'd0, bus.branchTaken_r}, 32'd0);
    check("rst2_comb",     bus.newpc, 32'd460);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
